// File: rtl/mem_if_pkg.sv
// Shared definitions for the CPU-side memory access path: op encodings,
// controller FSM states and default bus widths.
package mem_if_pkg;

   localparam int ADDR_W_DEF = 8;
   localparam int DATA_W_DEF = 8;

   localparam logic [1:0] OP_READ  = 2'b00;
   localparam logic [1:0] OP_WRITE = 2'b01;
   localparam logic [1:0] OP_FETCH = 2'b10;
   localparam logic [1:0] OP_RSVD  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   // Fetch is a read that also loads the instruction register.
   function automatic logic op_reads(input logic [1:0] op);
      return (op == OP_READ) || (op == OP_FETCH);
   endfunction

endpackage

// File: rtl/mem_access_ctrl.sv
// Single-outstanding initiator for the 8-bit Memory block: issues one strobe
// cycle per request, captures read/fetch data after READ_LAT and returns a
// one-cycle response.
module mem_access_ctrl
   import mem_if_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int DATA_W   = DATA_W_DEF,
   parameter int READ_LAT = 1
) (
   input  logic              power,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_op,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_err,
   output logic              busy,
   output logic              mem_write,
   output logic              mem_read,
   output logic              mem_ir_en,
   output logic [ADDR_W-1:0] mem_add,
   output logic [DATA_W-1:0] mem_data_in,
   input  logic [DATA_W-1:0] mem_data_out,
   input  logic [DATA_W-1:0] mem_ir_out
);

   localparam logic [1:0] LAT_INIT = READ_LAT[1:0];

   state_t            state;
   logic [1:0]        op_q;
   logic [DATA_W-1:0] wdata_q;
   logic [1:0]        lat_cnt;

   assign req_ready = (state == ST_IDLE) && !reset;
   assign busy      = (state != ST_IDLE);

   // The counter is loaded with READ_LAT when leaving ISSUE and the capture
   // happens on the edge that takes it to zero, i.e. READ_LAT edges later.
   always_ff @(posedge power or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         op_q        <= OP_READ;
         wdata_q     <= '0;
         lat_cnt     <= 2'd0;
         mem_write   <= 1'b0;
         mem_read    <= 1'b0;
         mem_ir_en   <= 1'b0;
         mem_add     <= '0;
         mem_data_in <= '0;
         rsp_valid   <= 1'b0;
         rsp_err     <= 1'b0;
         rsp_data    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  op_q    <= req_op;
                  wdata_q <= req_wdata;
                  if (req_op == OP_RSVD) begin
                     state     <= ST_RESP;
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                     rsp_data  <= '0;
                  end else begin
                     state     <= ST_ISSUE;
                     mem_add   <= req_addr;
                     mem_write <= (req_op == OP_WRITE);
                     mem_read  <= op_reads(req_op);
                     mem_ir_en <= (req_op == OP_FETCH);
                     if (req_op == OP_WRITE) begin
                        mem_data_in <= req_wdata;
                     end
                  end
               end
            end

            ST_ISSUE: begin
               mem_write <= 1'b0;
               mem_read  <= 1'b0;
               mem_ir_en <= 1'b0;
               if (op_q == OP_WRITE) begin
                  state     <= ST_RESP;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b0;
                  rsp_data  <= wdata_q;
               end else if (READ_LAT == 0) begin
                  state     <= ST_RESP;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b0;
                  rsp_data  <= (op_q == OP_FETCH) ? mem_ir_out : mem_data_out;
               end else begin
                  state   <= ST_WAIT;
                  lat_cnt <= LAT_INIT;
               end
            end

            ST_WAIT: begin
               lat_cnt <= lat_cnt - 2'd1;
               if (lat_cnt == 2'd1) begin
                  state     <= ST_RESP;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b0;
                  rsp_data  <= (op_q == OP_FETCH) ? mem_ir_out : mem_data_out;
               end
            end

            ST_RESP: begin
               state     <= ST_IDLE;
               rsp_valid <= 1'b0;
               rsp_err   <= 1'b0;
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: four controllers with READ_LAT 0..3, each with its
// own latency-accurate Memory model, checked through a response scoreboard.
module tb_mem_access_ctrl;
   import mem_if_pkg::*;

   typedef struct {
      int         inst;
      logic [1:0] op;
      logic [7:0] addr;
      logic [7:0] wdata;
      logic [7:0] exp_data;
      logic       exp_err;
   } vec_t;

   typedef struct {
      int         inst;
      logic [7:0] data;
      logic       err;
      int         due;
      int         wr;
      int         rd;
      int         ir;
      logic [7:0] addr;
      logic [7:0] wdata;
   } exp_t;

   logic       power = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] req_op;
   logic [7:0] req_addr;
   logic [7:0] req_wdata;

   logic       req_valid_v   [4];
   logic       req_ready_v   [4];
   logic       rsp_valid_v   [4];
   logic       rsp_err_v     [4];
   logic       busy_v        [4];
   logic       mem_write_v   [4];
   logic       mem_read_v    [4];
   logic       mem_ir_en_v   [4];
   logic [7:0] rsp_data_v    [4];
   logic [7:0] mem_add_v     [4];
   logic [7:0] mem_data_in_v [4];
   logic [7:0] mem_data_out_v[4];
   logic [7:0] mem_ir_out_v  [4];

   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   wr_cnt[4], rd_cnt[4], ir_cnt[4], rsp_count[4];
   logic [7:0] st_add[4], st_wdata[4];
   exp_t sb[$];
   exp_t mon_e;
   vec_t vecs[18];

   always #5 power = ~power;
   always @(posedge power) cyc <= cyc + 1;

   // Each controller gets a private Memory whose read data is only valid on
   // the edge READ_LAT after the one sampling mem_read; otherwise it is junk.
   for (genvar g = 0; g < 4; g++) begin : g_dut
      logic [7:0] mem [256];
      logic [1:0] cnt;
      logic [7:0] raddr;
      logic       rir;
      logic       valid;
      logic [7:0] a_sel;

      mem_access_ctrl #(.ADDR_W(8), .DATA_W(8), .READ_LAT(g)) u_dut (
         .power       (power),
         .reset       (reset),
         .req_valid   (req_valid_v[g]),
         .req_ready   (req_ready_v[g]),
         .req_op      (req_op),
         .req_addr    (req_addr),
         .req_wdata   (req_wdata),
         .rsp_valid   (rsp_valid_v[g]),
         .rsp_data    (rsp_data_v[g]),
         .rsp_err     (rsp_err_v[g]),
         .busy        (busy_v[g]),
         .mem_write   (mem_write_v[g]),
         .mem_read    (mem_read_v[g]),
         .mem_ir_en   (mem_ir_en_v[g]),
         .mem_add     (mem_add_v[g]),
         .mem_data_in (mem_data_in_v[g]),
         .mem_data_out(mem_data_out_v[g]),
         .mem_ir_out  (mem_ir_out_v[g])
      );

      initial begin
         cnt   = 2'd0;
         raddr = 8'd0;
         rir   = 1'b0;
         for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      end

      always @(posedge power) begin
         if (mem_write_v[g]) mem[mem_add_v[g]] <= mem_data_in_v[g];
         if (mem_read_v[g]) begin
            cnt   <= 2'(g);
            raddr <= mem_add_v[g];
            rir   <= mem_ir_en_v[g];
         end else if (cnt != 2'd0) begin
            cnt <= cnt - 2'd1;
         end
      end

      assign valid = (g == 0) ? mem_read_v[g] : (cnt == 2'd1);
      assign a_sel = (g == 0) ? mem_add_v[g] : raddr;
      assign mem_data_out_v[g] = valid ? mem[a_sel] : 8'hEE;
      assign mem_ir_out_v[g]   = (valid && ((g == 0) ? mem_ir_en_v[g] : rir)) ? mem[a_sel] : 8'hDD;
   end

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   function automatic int exp_lat(input logic [1:0] op, input int k);
      if (op == OP_WRITE) return 1;
      if (op == OP_RSVD) return 0;
      return 1 + k;
   endfunction

   // Response monitor: strobe bookkeeping, invariants and scoreboard pops.
   always @(negedge power) begin
      for (int k = 0; k < 4; k++) begin
         if (reset) begin
            wr_cnt[k] = 0;
            rd_cnt[k] = 0;
            ir_cnt[k] = 0;
         end else begin
            if (mem_write_v[k]) begin
               wr_cnt[k]++;
               st_add[k]   = mem_add_v[k];
               st_wdata[k] = mem_data_in_v[k];
               check_output("rd_wr_exclusive", mem_read_v[k], 0);
            end
            if (mem_read_v[k]) begin
               rd_cnt[k]++;
               st_add[k] = mem_add_v[k];
            end
            if (mem_ir_en_v[k]) begin
               ir_cnt[k]++;
               check_output("ir_implies_rd", mem_read_v[k], 1);
            end
            if (!rsp_valid_v[k]) check_output("rsp_err_idle", rsp_err_v[k], 0);
            if (rsp_valid_v[k]) begin
               if (sb.size() == 0) begin
                  check_output("unexpected_rsp", k, 32'hFFFF);
               end else begin
                  mon_e = sb.pop_front();
                  check_output("rsp_inst", k, mon_e.inst);
                  check_output("rsp_data", rsp_data_v[k], mon_e.data);
                  check_output("rsp_err", rsp_err_v[k], mon_e.err);
                  check_output("rsp_cycle", cyc, mon_e.due);
                  check_output("write_strobes", wr_cnt[k], mon_e.wr);
                  check_output("read_strobes", rd_cnt[k], mon_e.rd);
                  check_output("ir_strobes", ir_cnt[k], mon_e.ir);
                  if (mon_e.wr != 0 || mon_e.rd != 0) check_output("strobe_addr", st_add[k], mon_e.addr);
                  if (mon_e.wr != 0) check_output("strobe_wdata", st_wdata[k], mon_e.wdata);
               end
               wr_cnt[k] = 0;
               rd_cnt[k] = 0;
               ir_cnt[k] = 0;
               rsp_count[k]++;
            end
         end
      end
   end

   // Called just after a falling edge; returns just after a falling edge.
   task automatic apply_stimulus(input int k, input logic [1:0] op, input logic [7:0] addr,
                                 input logic [7:0] wdata, input logic [7:0] exp_data,
                                 input logic exp_err, input bit hold, input bit wait_rsp,
                                 output int waits);
      exp_t e;
      int   c;
      int   base;
      bit   acc;
      acc   = 1'b0;
      c     = 0;
      waits = 0;
      req_op    = op;
      req_addr  = addr;
      req_wdata = wdata;
      req_valid_v[k] = 1'b1;
      for (int i = 0; i < 40; i++) begin
         c   = cyc;
         acc = req_ready_v[k];
         @(posedge power);
         if (acc) break;
         waits++;
         @(negedge power);
         #1;
      end
      if (!acc) begin
         check_output("accept_timeout", 0, 1);
         req_valid_v[k] = 1'b0;
         @(negedge power);
         #1;
         return;
      end
      e.inst  = k;
      e.data  = exp_data;
      e.err   = exp_err;
      e.due   = c + 1 + exp_lat(op, k);
      e.wr    = (op == OP_WRITE) ? 1 : 0;
      e.rd    = (op == OP_READ || op == OP_FETCH) ? 1 : 0;
      e.ir    = (op == OP_FETCH) ? 1 : 0;
      e.addr  = addr;
      e.wdata = wdata;
      sb.push_back(e);
      base = rsp_count[k];
      @(negedge power);
      #1;
      if (!hold) req_valid_v[k] = 1'b0;
      if (wait_rsp) begin
         for (int i = 0; i < 20 && rsp_count[k] == base; i++) begin
            @(negedge power);
            #1;
         end
         check_output("rsp_seen", rsp_count[k] - base, 1);
         @(negedge power);
         #1;
         check_output("ready_after_resp", req_ready_v[k], 1);
      end
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int w;
      vecs[0]  = '{1, OP_WRITE, 8'd11,  8'd38,  8'd38,  1'b0};
      vecs[1]  = '{1, OP_READ,  8'd11,  8'd0,   8'd38,  1'b0};
      vecs[2]  = '{1, OP_WRITE, 8'd12,  8'd7,   8'd7,   1'b0};
      vecs[3]  = '{1, OP_FETCH, 8'd11,  8'd0,   8'd38,  1'b0};
      vecs[4]  = '{1, OP_RSVD,  8'd5,   8'd99,  8'd0,   1'b1};
      vecs[5]  = '{1, OP_READ,  8'd12,  8'd0,   8'd7,   1'b0};
      vecs[6]  = '{1, OP_WRITE, 8'd255, 8'hFF,  8'hFF,  1'b0};
      vecs[7]  = '{1, OP_READ,  8'd255, 8'd0,   8'hFF,  1'b0};
      vecs[8]  = '{1, OP_READ,  8'd0,   8'd0,   8'h00,  1'b0};
      vecs[9]  = '{0, OP_WRITE, 8'd11,  8'd38,  8'd38,  1'b0};
      vecs[10] = '{0, OP_READ,  8'd11,  8'd0,   8'd38,  1'b0};
      vecs[11] = '{0, OP_FETCH, 8'd11,  8'd0,   8'd38,  1'b0};
      vecs[12] = '{2, OP_WRITE, 8'd20,  8'hA5,  8'hA5,  1'b0};
      vecs[13] = '{2, OP_READ,  8'd20,  8'd0,   8'hA5,  1'b0};
      vecs[14] = '{2, OP_FETCH, 8'd20,  8'd0,   8'hA5,  1'b0};
      vecs[15] = '{3, OP_WRITE, 8'd11,  8'h5C,  8'h5C,  1'b0};
      vecs[16] = '{3, OP_READ,  8'd11,  8'd0,   8'h5C,  1'b0};
      vecs[17] = '{3, OP_FETCH, 8'd11,  8'd0,   8'h5C,  1'b0};

      for (int k = 0; k < 4; k++) begin
         req_valid_v[k] = 1'b0;
         wr_cnt[k] = 0;
         rd_cnt[k] = 0;
         ir_cnt[k] = 0;
         rsp_count[k] = 0;
         st_add[k] = 8'd0;
         st_wdata[k] = 8'd0;
      end
      req_op    = OP_READ;
      req_addr  = 8'd0;
      req_wdata = 8'd0;

      reset = 1'b1;
      repeat (2) @(negedge power);
      #1;
      check_output("reset_rsp_valid", rsp_valid_v[1], 0);
      check_output("reset_rsp_err", rsp_err_v[1], 0);
      check_output("reset_rsp_data", rsp_data_v[1], 0);
      check_output("reset_mem_write", mem_write_v[1], 0);
      check_output("reset_mem_read", mem_read_v[1], 0);
      check_output("reset_mem_ir_en", mem_ir_en_v[1], 0);
      check_output("reset_mem_add", mem_add_v[1], 0);
      check_output("reset_mem_data_in", mem_data_in_v[1], 0);
      check_output("reset_req_ready", req_ready_v[1], 0);
      check_output("reset_busy", busy_v[1], 0);
      reset = 1'b0;
      #1;
      check_output("release_req_ready", req_ready_v[1], 1);
      @(negedge power);
      #1;

      for (int i = 0; i < 18; i++) begin
         apply_stimulus(vecs[i].inst, vecs[i].op, vecs[i].addr, vecs[i].wdata,
                        vecs[i].exp_data, vecs[i].exp_err, 1'b0, 1'b1, w);
      end

      // Back-to-back with req_valid held: the write waits out ISSUE, WAIT, RESP.
      apply_stimulus(1, OP_READ, 8'd11, 8'd0, 8'd38, 1'b0, 1'b1, 1'b0, w);
      apply_stimulus(1, OP_WRITE, 8'd11, 8'd45, 8'd45, 1'b0, 1'b0, 1'b1, w);
      check_output("b2b_ready_low_cycles", w, 3);
      apply_stimulus(1, OP_READ, 8'd11, 8'd0, 8'd45, 1'b0, 1'b0, 1'b1, w);

      // Reset in the middle of a READ_LAT=3 wait discards the transaction.
      apply_stimulus(3, OP_READ, 8'd11, 8'd0, 8'h5C, 1'b0, 1'b0, 1'b0, w);
      @(negedge power);
      #1;
      @(negedge power);
      #1;
      check_output("midwait_busy", busy_v[3], 1);
      reset = 1'b1;
      #1;
      check_output("midreset_mem_read", mem_read_v[3], 0);
      check_output("midreset_mem_write", mem_write_v[3], 0);
      check_output("midreset_mem_ir_en", mem_ir_en_v[3], 0);
      check_output("midreset_rsp_valid", rsp_valid_v[3], 0);
      check_output("midreset_busy", busy_v[3], 0);
      check_output("midreset_req_ready", req_ready_v[3], 0);
      check_output("midreset_pending", sb.size(), 1);
      if (sb.size() > 0) void'(sb.pop_back());
      repeat (3) begin
         @(negedge power);
         #1;
      end
      reset = 1'b0;
      #1;
      check_output("postreset_req_ready", req_ready_v[3], 1);
      @(negedge power);
      #1;
      apply_stimulus(3, OP_READ, 8'd11, 8'd0, 8'h5C, 1'b0, 1'b0, 1'b1, w);

      repeat (3) @(negedge power);
      #1;
      check_output("scoreboard_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
CPU-side initiator for the 8-bit Memory block. It accepts one read, write or instruction-fetch request at a time from the core and drives the Memory strobes (write, read, ir_en), address and write data. It captures data_out or ir_out after a fixed read latency and returns a single-cycle response to the core. It sits between the control unit/PC logic and Memory, and is the only driver of Memory's inputs.

Parameters:
ADDR_W, 8, address width (matches Memory add)
DATA_W, 8, data width (matches Memory data_in/data_out/ir_out)
READ_LAT, 1, cycles from the edge that samples mem_read to the edge at which Memory read data is valid; legal range 0..3

Ports:
power  in  1  clock, rising edge (codebase clock name)
reset  in  1  asynchronous, active-high
req_valid  in  1  core request present
req_ready  out  1  controller can accept a request
req_op  in  2  00 read, 01 write, 10 fetch, 11 reserved
req_addr  in  ADDR_W  request address
req_wdata  in  DATA_W  write data
rsp_valid  out  1  one-cycle response pulse
rsp_data  out  DATA_W  read/fetch data; write echoes wdata; 0 on error
rsp_err  out  1  qualifies rsp_valid; set for reserved op
busy  out  1  state != IDLE
mem_write  out  1  to Memory write
mem_read  out  1  to Memory read
mem_ir_en  out  1  to Memory ir_en
mem_add  out  ADDR_W  to Memory add
mem_data_in  out  DATA_W  to Memory data_in
mem_data_out  in  DATA_W  from Memory data_out
mem_ir_out  in  DATA_W  from Memory ir_out

Behaviour:
- Clocking and reset: one clock (power). Reset is asynchronous and active-high.
- Reset values: state IDLE; mem_write, mem_read, mem_ir_en, rsp_valid and rsp_err = 0; mem_add, mem_data_in and rsp_data = 0; lat counter = 0. req_ready = (state==IDLE) && !reset.
- All outputs except req_ready and busy are registered.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: handshake completes at edge E when req_valid && req_ready. At E the controller latches op, addr and wdata, then:
  - op 00/01/10 -> ISSUE.
  - op 11 -> RESP with rsp_err=1, rsp_data=0. No Memory strobes are driven.
- ISSUE: spans cycle E..E+1.
  - mem_add = addr.
  - write: mem_write=1 and mem_data_in=wdata.
  - read: mem_read=1.
  - fetch: mem_read=1 and mem_ir_en=1.
  - Strobes are high for exactly one cycle.
  - write -> RESP at E+1.
  - read/fetch -> WAIT at E+1 with lat counter = READ_LAT.
- WAIT: strobes are 0. The counter decrements each edge. When the counter is 0, that edge captures mem_data_out (read) or mem_ir_out (fetch) into rsp_data, and the state goes to RESP.
  - The capture edge is E+1+READ_LAT.
  - READ_LAT=0 captures at E+1 directly from ISSUE, skipping WAIT.
- RESP: rsp_valid=1 for exactly one cycle; there is no back-pressure. Write responses have rsp_data = wdata. Next state is IDLE.
- Latency from accept edge to rsp_valid:
  - write: 1 cycle.
  - read/fetch: 1+READ_LAT cycles.
  - reserved op: 0 extra cycles (rsp in the cycle after accept).
  - req_ready returns to 1 in the cycle after RESP.
- mem_add and mem_data_in hold their last values between transactions. They never change while a strobe is high.
- Invariants: mem_read && mem_write is never 1; mem_ir_en implies mem_read.
- req_valid while req_ready=0 is ignored; the requester holds the request.
- Reset mid-operation: all strobes and rsp_valid drop immediately. The in-flight transaction is discarded with no response. After release the block is in IDLE with req_ready=1.
- rsp_err is 0 on every non-reserved response and is held 0 whenever rsp_valid=0.

Decomposition:
- Package mem_if_pkg holds:
  - op encodings OP_READ=2'b00, OP_WRITE=2'b01, OP_FETCH=2'b10, OP_RSVD=2'b11;
  - the FSM state enum;
  - ADDR_W/DATA_W defaults.
- No sub-module. There is a single FSM plus a 2-bit latency counter. The Memory model is instantiated only in the bench.

Test Plan:
- Write 38 to addr 11, then read 11 (READ_LAT=1):
  - mem_write high exactly one cycle with mem_add=11, mem_data_in=38;
  - write rsp_data=38 one cycle after accept;
  - read rsp_valid two cycles after accept with rsp_data=38, rsp_err=0.
- Write 7 to addr 12, then fetch addr 11:
  - fetch drives mem_read=1, mem_ir_en=1 together for one cycle;
  - rsp_data = mem_ir_out = 38;
  - mem_write never high during the fetch.
- Reserved op 11 at addr 5: no strobes; rsp_valid the next cycle with rsp_err=1, rsp_data=0; req_ready=1 the cycle after.
- Back-to-back: req_valid held high with read 11 then write 45 to 11. The second request is accepted only after the first RESP; a following read returns 45; req_ready=0 throughout busy.
- Reset asserted mid-WAIT (READ_LAT=3, read addr 11):
  - strobes and rsp_valid are 0 immediately and no response appears;
  - after release a new read of 11 completes normally in 4 cycles.
- Latency sweep: READ_LAT=0 and 2 give read rsp_valid at accept+1 and accept+3 respectively.
